// File: rtl/lpgbt_fe_pkg.sv
// Shared lpGBT front-end constants: frame geometry, default header, gearbox state
// encoding and small frame-building helpers.
package lpgbt_fe_pkg;

    localparam int FRAME_WIDTH   = 64;
    localparam int PAYLOAD_WIDTH = 53;
    localparam int FEC_WIDTH     = 7;
    localparam int HEADER_WIDTH  = 4;

    localparam logic [HEADER_WIDTH-1:0] DEFAULT_HEADER = 4'b1001;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic [FRAME_WIDTH-1:0] build_frame(
        input logic [HEADER_WIDTH-1:0]  header,
        input logic [FEC_WIDTH-1:0]     fec,
        input logic [PAYLOAD_WIDTH-1:0] data
    );
        return {header, fec, data};
    endfunction

    // An idle frame carries the header so the receiver keeps frame lock.
    function automatic logic [FRAME_WIDTH-1:0] idle_frame(
        input logic [HEADER_WIDTH-1:0] header
    );
        return {header, {(FRAME_WIDTH-HEADER_WIDTH){1'b0}}};
    endfunction

endpackage

// File: rtl/tx_frame_gearbox53_if.sv
// Bundle between the scrambler/FEC side and the transmit gearbox, plus the
// gearbox status outputs.
interface tx_frame_gearbox53_if #(
    parameter int WORD_WIDTH = 16
);
    import lpgbt_fe_pkg::*;

    // Handshake: a frame {fec, data} transfers on a cycle where frame_valid
    // and frame_ready are both 1; frame_ready never depends on frame_valid.
    // frame_valid while frame_ready is 0 drops the frame and flags cadence_err.
    logic [PAYLOAD_WIDTH-1:0] data;
    logic [FEC_WIDTH-1:0]     fec;
    logic                     frame_valid;
    logic                     frame_ready;

    logic [WORD_WIDTH-1:0]    word_out;
    logic                     frame_start;
    logic                     running;
    logic                     underflow;
    logic                     cadence_err;
    logic [7:0]               err_count;
    state_e                   dbg_state;

    modport master (
        output data, fec, frame_valid,
        input  frame_ready, word_out, frame_start, running,
        input  underflow, cadence_err, err_count, dbg_state
    );

    modport slave (
        input  data, fec, frame_valid,
        output frame_ready, word_out, frame_start, running,
        output underflow, cadence_err, err_count, dbg_state
    );

endinterface

// File: rtl/tx_frame_gearbox53_err_sat_counter.sv
// Saturating event counter: counts up on inc, holds at all-ones, cleared only
// by reset.
module err_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/tx_frame_gearbox53.sv
// Transmit gearbox: packs {HEADER, fec, data} into a 64-bit frame and shifts it
// out MSB-first as 64/WORD_WIDTH words, inserting idle frames on underflow.
module tx_frame_gearbox53
    import lpgbt_fe_pkg::*;
#(
    parameter int                      WORD_WIDTH = 16,
    parameter logic [HEADER_WIDTH-1:0] HEADER     = DEFAULT_HEADER,
    parameter int                      MISS_LIMIT = 4
) (
    input  logic               clock,
    input  logic               reset,
    tx_frame_gearbox53_if.slave bus
);

    localparam int RATIO = FRAME_WIDTH / WORD_WIDTH;
    localparam int CNT_W = (RATIO > 2) ? $clog2(RATIO) : 1;

    localparam logic [CNT_W-1:0]       CNT_LAST   = CNT_W'(RATIO - 1);
    localparam logic [3:0]             MISS_LAST  = 4'(MISS_LIMIT - 1);
    localparam logic [FRAME_WIDTH-1:0] IDLE_FRAME = idle_frame(HEADER);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [FRAME_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]       cnt;
    logic [0:0]             state;
    logic [3:0]             miss;
    logic                   underflow_q;
    logic                   cadence_err_q;
    logic [7:0]             err_count_q;

    logic at_last;
    logic ready;
    logic accept;
    logic miss_ev;
    logic cad_ev;

    assign at_last = (cnt == CNT_LAST);
    // In IDLE every cycle is a load point, so a frame is taken immediately.
    assign ready   = (state == ST_IDLE) | at_last;
    assign accept  = bus.frame_valid & ready;
    assign miss_ev = (state == ST_RUN) & at_last & ~bus.frame_valid;
    assign cad_ev  = bus.frame_valid & ~ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg         <= IDLE_FRAME;
            cnt           <= '0;
            state         <= ST_IDLE;
            miss          <= '0;
            underflow_q   <= 1'b0;
            cadence_err_q <= 1'b0;
        end else begin
            underflow_q   <= miss_ev;
            cadence_err_q <= cad_ev;
            if (accept) begin
                shreg <= build_frame(HEADER, bus.fec, bus.data);
                cnt   <= '0;
                miss  <= '0;
                state <= ST_RUN;
            end else if (at_last) begin
                shreg <= IDLE_FRAME;
                cnt   <= '0;
                // Consecutive misses only count while running.
                if (state == ST_RUN) begin
                    if (miss == MISS_LAST) begin
                        state <= ST_IDLE;
                        miss  <= '0;
                    end else begin
                        miss <= miss + 4'd1;
                    end
                end
            end else begin
                shreg <= shreg << WORD_WIDTH;
                cnt   <= cnt + CNT_W'(1);
            end
        end
    end

    // An underflow needs RUN at a load point, a cadence error needs a non-load
    // point, so at most one increment arrives per cycle.
    err_sat_counter #(
        .WIDTH (8)
    ) u_err_count (
        .clock (clock),
        .reset (reset),
        .inc   (miss_ev | cad_ev),
        .count (err_count_q)
    );

    assign bus.word_out    = shreg[FRAME_WIDTH-1 -: WORD_WIDTH];
    assign bus.frame_ready = ready;
    assign bus.frame_start = (cnt == '0);
    assign bus.running     = (state == ST_RUN);
    assign bus.underflow   = underflow_q;
    assign bus.cadence_err = cadence_err_q;
    assign bus.err_count   = err_count_q;
    assign bus.dbg_state   = state_e'(state);

endmodule

// File: tb/tb_tx_frame_gearbox53.sv
// Bench for tx_frame_gearbox53: a frame-level model checks the 16-bit instance
// every cycle; 8- and 32-bit instances are checked against literal words.
module tb_tx_frame_gearbox53;
    import lpgbt_fe_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    tx_frame_gearbox53_if #(.WORD_WIDTH(16)) bus16 ();
    tx_frame_gearbox53_if #(.WORD_WIDTH(8))  bus8  ();
    tx_frame_gearbox53_if #(.WORD_WIDTH(32)) bus32 ();

    tx_frame_gearbox53 #(.WORD_WIDTH(16)) dut16 (.clock(clock), .reset(reset), .bus(bus16));
    tx_frame_gearbox53 #(.WORD_WIDTH(8))  dut8  (.clock(clock), .reset(reset), .bus(bus8));
    tx_frame_gearbox53 #(.WORD_WIDTH(32)) dut32 (.clock(clock), .reset(reset), .bus(bus32));

    always #5 clock = ~clock;

    localparam logic [63:0] IDLE_F = 64'h9000_0000_0000_0000;
    localparam logic [52:0] DATA_A = 53'h1f16348aab1a1a;
    localparam logic [6:0]  FEC_A  = 7'h55;
    // {4'b1001, 7'h55, DATA_A} = 64'h9ABF_1634_8AAB_1A1A
    logic [15:0] exp16_a [4] = '{16'h9ABF, 16'h1634, 16'h8AAB, 16'h1A1A};
    logic [7:0]  exp8_a  [8] = '{8'h9A, 8'hBF, 8'h16, 8'h34, 8'h8A, 8'hAB, 8'h1A, 8'h1A};
    logic [31:0] exp32_a [2] = '{32'h9ABF1634, 32'h8AAB1A1A};

    // Frame-level model of the 16-bit instance: the frame on the line and
    // which of its four words is showing.
    logic [63:0] m_frame = IDLE_F;
    int          m_idx   = 0;
    bit          m_run   = 0;
    int          m_miss  = 0;
    int          m_err   = 0;
    bit          m_uf    = 0;
    bit          m_ce    = 0;
    bit          cmp_en  = 0;
    logic [15:0] m_word;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic void bump_err();
        if (m_err < 255) m_err++;
    endfunction

    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            m_frame = IDLE_F; m_idx = 0; m_run = 0; m_miss = 0; m_err = 0;
            m_uf = 0; m_ce = 0;
        end else begin
            bit rdy;
            rdy  = !m_run || (m_idx == 3);
            m_uf = 0;
            m_ce = 0;
            if (bus16.frame_valid && rdy) begin
                m_frame = {4'b1001, bus16.fec, bus16.data};
                m_idx = 0; m_run = 1; m_miss = 0;
            end else if (m_idx == 3) begin
                m_frame = IDLE_F;
                m_idx = 0;
                if (m_run) begin
                    m_uf = 1;
                    bump_err();
                    m_miss++;
                    if (m_miss == 4) begin
                        m_run = 0; m_miss = 0;
                    end
                end
            end else begin
                m_idx++;
                if (bus16.frame_valid && !rdy) begin
                    m_ce = 1;
                    bump_err();
                end
            end
        end
    end

    initial forever begin
        @(negedge clock);
        if (cmp_en) begin
            m_word = 16'(m_frame >> (48 - 16 * m_idx));
            chk("word_out",    64'(bus16.word_out),    64'(m_word));
            chk("frame_ready", 64'(bus16.frame_ready), 64'(!m_run || m_idx == 3));
            chk("frame_start", 64'(bus16.frame_start), 64'(m_idx == 0));
            chk("running",     64'(bus16.running),     64'(m_run));
            chk("dbg_state",   64'(bus16.dbg_state),   64'(m_run));
            chk("underflow",   64'(bus16.underflow),   64'(m_uf));
            chk("cadence_err", 64'(bus16.cadence_err), 64'(m_ce));
            chk("err_count",   64'(bus16.err_count),   64'(m_err));
        end
    end

    task automatic send16(input logic [52:0] d, input logic [6:0] f);
        int n;
        n = 0;
        while (bus16.frame_ready !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        if (n >= 16) begin
            checks++;
            errors++;
            $display("FAIL send16_ready_timeout: got no frame_ready within %0d cycles", n);
        end
        bus16.data = d;
        bus16.fec = f;
        bus16.frame_valid = 1'b1;
        tick();
        bus16.frame_valid = 1'b0;
    endtask

    task automatic reset_literals(input string tag);
        chk({tag, "_word"},  64'(bus16.word_out),    64'h9000);
        chk({tag, "_ready"}, 64'(bus16.frame_ready), 64'd1);
        chk({tag, "_start"}, 64'(bus16.frame_start), 64'd1);
        chk({tag, "_run"},   64'(bus16.running),     64'd0);
        chk({tag, "_uf"},    64'(bus16.underflow),   64'd0);
        chk({tag, "_ce"},    64'(bus16.cadence_err), 64'd0);
        chk({tag, "_err"},   64'(bus16.err_count),   64'd0);
    endtask

    initial begin
        logic [52:0] data_b;
        logic [6:0]  fec_b;
        logic [63:0] frame_b;
        int          n_uf;

        bus16.data = '0; bus16.fec = '0; bus16.frame_valid = 1'b0;
        bus8.data  = '0; bus8.fec  = '0; bus8.frame_valid  = 1'b0;
        bus32.data = '0; bus32.fec = '0; bus32.frame_valid = 1'b0;

        repeat (3) @(negedge clock);
        reset_literals("reset");
        chk("reset_word8",  64'(bus8.word_out),  64'h90);
        chk("reset_word32", 64'(bus32.word_out), 64'h9000_0000);
        @(posedge clock);
        #1;
        reset = 1'b0;
        cmp_en = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            chk("idle_word", 64'(bus16.word_out), (i % 4 == 0) ? 64'h9000 : 64'h0);
            tick();
        end
        @(negedge clock);
        chk("idle_running", 64'(bus16.running),   64'd0);
        chk("idle_err",     64'(bus16.err_count), 64'd0);

        send16(DATA_A, FEC_A);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("frame_a_word", 64'(bus16.word_out), 64'(exp16_a[k]));
            if (k == 0) begin
                chk("frame_a_start",   64'(bus16.frame_start), 64'd1);
                chk("frame_a_running", 64'(bus16.running),     64'd1);
            end
            if (k < 3) tick();
        end

        for (int f = 0; f < 100; f++) begin
            send16(53'({$urandom(), $urandom()}), 7'($urandom_range(0, 127)));
        end
        @(negedge clock);
        chk("stream_err", 64'(bus16.err_count), 64'd0);

        n_uf = 0;
        repeat (24) begin
            @(negedge clock);
            if (bus16.underflow === 1'b1) n_uf++;
            tick();
        end
        chk("underflow_pulses", 64'(n_uf), 64'd4);
        @(negedge clock);
        chk("underflow_running", 64'(bus16.running),   64'd0);
        chk("underflow_err",     64'(bus16.err_count), 64'd4);

        data_b  = 53'h0_0123_4567_89AB;
        fec_b   = 7'h2A;
        frame_b = {4'b1001, fec_b, data_b};
        send16(data_b, fec_b);
        tick();
        bus16.data = 53'h1F_FFFF_FFFF_FFFF;
        bus16.fec = 7'h7F;
        bus16.frame_valid = 1'b1;
        tick();
        bus16.frame_valid = 1'b0;
        @(negedge clock);
        chk("cadence_pulse", 64'(bus16.cadence_err), 64'd1);
        chk("cadence_err",   64'(bus16.err_count),   64'd5);
        chk("cadence_word",  64'(bus16.word_out),    64'(frame_b[31:16]));

        #2;
        reset = 1'b1;
        #1;
        reset_literals("midreset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        bus16.data = DATA_A;
        bus16.fec = FEC_A;
        bus16.frame_valid = 1'b1;
        tick();
        bus16.frame_valid = 1'b0;
        @(negedge clock);
        chk("post_reset_word",    64'(bus16.word_out), 64'(exp16_a[0]));
        chk("post_reset_running", 64'(bus16.running),  64'd1);

        bus8.data = DATA_A;
        bus8.fec = FEC_A;
        bus8.frame_valid = 1'b1;
        tick();
        bus8.frame_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            chk("w8_word", 64'(bus8.word_out), 64'(exp8_a[k]));
            if (k == 0) chk("w8_start", 64'(bus8.frame_start), 64'd1);
            if (k < 7) tick();
        end

        bus32.data = DATA_A;
        bus32.fec = FEC_A;
        bus32.frame_valid = 1'b1;
        tick();
        bus32.frame_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            chk("w32_word", 64'(bus32.word_out), 64'(exp32_a[k]));
            if (k == 0) chk("w32_start", 64'(bus32.frame_start), 64'd1);
            if (k < 1) tick();
        end

        repeat (8) tick();
        @(negedge clock);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
